// File: rtl/pci_defs.sv
// Shared PCI definitions: bus command codes and target state encodings.
// Imported by the target and intended for reuse by initiator/arbiter benches.
package pci_defs;

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TURN    = 2'd1,
    ST_DATA    = 2'd2,
    ST_BACKOFF = 2'd3
  } tgt_state_t;

  function automatic logic is_mem_cmd(input logic [3:0] cmd);
    return (cmd == CMD_MEM_RD) || (cmd == CMD_MEM_WR);
  endfunction

endpackage

// File: rtl/target_buffer.sv
// DEPTH x 32-bit word store behind the PCI target.
// Ports:
//   clk    in  clock
//   we     in  write strobe (one word per cycle)
//   be     in  per-byte-lane write enables, active high
//   waddr  in  write word index
//   wdata  in  write data
//   raddr  in  read word index (asynchronous read)
//   rdata  out read data
// Contents are deliberately not reset.
module target_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int n = 0; n < 4; n++) begin
        if (be[n]) mem[waddr][8*n +: 8] <= wdata[8*n +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/simple_target.sv
// PCI-style memory target. Decodes single/burst memory read and write
// transactions at BASE_ADDR and completes them against a DEPTH-word buffer.
// Ports:
//   clk     in  bus clock, everything on posedge
//   rst     in  asynchronous active-high reset
//   FRAME   in  bus FRAME (active low)
//   IRDY    in  bus IRDY (active low)
//   C_BE    in  command in address phase, byte enables (active low) in data phases
//   AD_in   in  address/data from the bus
//   AD_out  out read data to the bus
//   AD_oe   out target drives AD (read data phases)
//   DEVSEL  out device select (active low)
//   TRDY    out target ready (active low)
//   STOP    out disconnect request (active low)
// All outputs come straight from flops.
module simple_target
  import pci_defs::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FRAME,
  input  logic        IRDY,
  input  logic [3:0]  C_BE,
  input  logic [31:0] AD_in,
  output logic [31:0] AD_out,
  output logic        AD_oe,
  output logic        DEVSEL,
  output logic        TRDY,
  output logic        STOP
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  tgt_state_t    state, state_nxt;
  logic [AW-1:0] idx, idx_nxt, idx_inc, dec_idx, rd_idx;
  logic          is_wr, is_wr_nxt;
  logic          done, done_nxt;
  logic          frame_q;
  logic          devsel_nxt, trdy_nxt, stop_nxt, ad_oe_nxt;
  logic [31:0]   ad_out_nxt;
  logic          addr_phase, hit, rel;
  logic          buf_we;
  logic [31:0]   rd_data;

  // Address phase is the first edge with FRAME low after it was seen high.
  assign addr_phase = !FRAME && frame_q;
  assign hit        = addr_phase && (AD_in[31:AW+2] == BASE_ADDR[31:AW+2]) && is_mem_cmd(C_BE);
  assign dec_idx    = AD_in[AW+1:2];
  assign idx_inc    = idx + AW'(1);
  // Idle looks up the decoded word for the turnaround; in a burst it prefetches the next word.
  assign rd_idx     = (state == ST_IDLE) ? dec_idx : idx_inc;

  // TRDY is always low in DATA until the disconnect completes, so IRDY alone marks a transfer.
  assign buf_we = (state == ST_DATA) && !done && is_wr && !IRDY;

  target_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .be    (~C_BE),
    .waddr (idx),
    .wdata (AD_in),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    is_wr_nxt  = is_wr;
    done_nxt   = done;
    devsel_nxt = DEVSEL;
    trdy_nxt   = TRDY;
    stop_nxt   = STOP;
    ad_oe_nxt  = AD_oe;
    ad_out_nxt = AD_out;
    rel        = 1'b0;

    case (state)
      ST_IDLE: begin
        devsel_nxt = 1'b1;
        trdy_nxt   = 1'b1;
        stop_nxt   = 1'b1;
        ad_oe_nxt  = 1'b0;
        done_nxt   = 1'b0;
        if (hit) begin
          idx_nxt    = dec_idx;
          is_wr_nxt  = (C_BE == CMD_MEM_WR);
          devsel_nxt = 1'b0;
          if (C_BE == CMD_MEM_WR) begin
            state_nxt = ST_DATA;
            trdy_nxt  = 1'b0;
            stop_nxt  = (dec_idx != LAST);
          end else begin
            state_nxt  = ST_TURN;
            ad_oe_nxt  = 1'b1;
            ad_out_nxt = rd_data;
          end
        end
      end

      ST_TURN: begin
        if (FRAME && IRDY) begin
          rel = 1'b1;
        end else begin
          state_nxt = ST_DATA;
          trdy_nxt  = 1'b0;
          stop_nxt  = (idx != LAST);
        end
      end

      ST_DATA: begin
        if (done) begin
          // Disconnect already taken: wait for the initiator to drop FRAME.
          if (FRAME) rel = 1'b1;
        end else if (!IRDY) begin
          if (FRAME) begin
            rel = 1'b1;
          end else if (idx == LAST) begin
            trdy_nxt = 1'b1;
            done_nxt = 1'b1;
          end else begin
            idx_nxt  = idx_inc;
            stop_nxt = (idx_inc != LAST);
            if (!is_wr) ad_out_nxt = rd_data;
          end
        end else if (FRAME) begin
          rel = 1'b1;
        end
      end

      ST_BACKOFF: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (rel) begin
      state_nxt  = ST_BACKOFF;
      devsel_nxt = 1'b1;
      trdy_nxt   = 1'b1;
      stop_nxt   = 1'b1;
      ad_oe_nxt  = 1'b0;
      ad_out_nxt = '0;
      done_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      is_wr   <= 1'b0;
      done    <= 1'b0;
      frame_q <= 1'b1;
      DEVSEL  <= 1'b1;
      TRDY    <= 1'b1;
      STOP    <= 1'b1;
      AD_oe   <= 1'b0;
      AD_out  <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      is_wr   <= is_wr_nxt;
      done    <= done_nxt;
      frame_q <= FRAME;
      DEVSEL  <= devsel_nxt;
      TRDY    <= trdy_nxt;
      STOP    <= stop_nxt;
      AD_oe   <= ad_oe_nxt;
      AD_out  <= ad_out_nxt;
    end
  end

endmodule

// File: tb/tb_simple_target.sv
// Scoreboard bench for simple_target: the initiator task queues the expected
// transfers of each transaction; a monitor pops one entry per bus transfer.
module tb_simple_target;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;
  localparam logic [3:0]  RD    = 4'b0110;
  localparam logic [3:0]  WR    = 4'b0111;

  logic        clk, rst, FRAME, IRDY;
  logic [3:0]  C_BE;
  logic [31:0] AD_in, AD_out;
  logic        AD_oe, DEVSEL, TRDY, STOP;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rd;
    int          idx;
    logic [31:0] data;
    logic [3:0]  be;
    bit          stop;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] wdat [32];
  logic [3:0]  wbe  [32];

  simple_target #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .FRAME  (FRAME),
    .IRDY   (IRDY),
    .C_BE   (C_BE),
    .AD_in  (AD_in),
    .AD_out (AD_out),
    .AD_oe  (AD_oe),
    .DEVSEL (DEVSEL),
    .TRDY   (TRDY),
    .STOP   (STOP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer completes on the edge following a negedge where IRDY and TRDY are low.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !IRDY && !TRDY) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer got transfer expected none at %0t", $time);
      end else begin
        e = sbq.pop_front();
        chk("stop_at_xfer", STOP, e.stop ? 32'd0 : 32'd1);
        if (e.rd) begin
          chk("rd_oe", AD_oe, 32'd1);
          chk("rd_data", AD_out, e.data);
        end else begin
          for (int b = 0; b < 4; b++)
            if (!e.be[b]) model_mem[e.idx][8*b +: 8] = e.data[8*b +: 8];
        end
      end
    end
  end

  // Initiator: runs one transaction; wdat/wbe hold the per-beat data and byte enables.
  task automatic txn(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                     input int wait_at, input int wait_len, input bit hold_stop, input int rst_at);
    bit   hit, rd, xfer, stp, fin;
    int   idx0, nx, k, waited, budget;
    exp_t e;
    rd   = (cmd == RD);
    hit  = (addr[31:6] == BASE[31:6]) && (cmd == RD || cmd == WR);
    idx0 = int'(addr[5:2]);
    nx   = hit ? ((n < DEPTH - idx0) ? n : DEPTH - idx0) : 0;
    for (int j = 0; j < nx; j++) begin
      e.rd   = rd;
      e.idx  = idx0 + j;
      e.data = rd ? model_mem[idx0 + j] : wdat[j];
      e.be   = wbe[j];
      e.stop = (idx0 + j == DEPTH - 1);
      sbq.push_back(e);
    end

    step();
    FRAME = 1'b0; IRDY = 1'b1; AD_in = addr; C_BE = cmd;
    step();

    if (!hit) begin
      FRAME = 1'b1; IRDY = 1'b0; AD_in = $urandom; C_BE = 4'h0;
      repeat (4) begin
        chk("miss_quiet", {DEVSEL, TRDY, STOP, AD_oe}, 4'b1110);
        step();
      end
      IRDY = 1'b1;
      return;
    end

    chk("decode", {DEVSEL, TRDY, AD_oe}, rd ? 3'b011 : 3'b000);
    k = 0; waited = 0; budget = 0; fin = 0;
    IRDY = 1'b0; AD_in = rd ? $urandom : wdat[0]; C_BE = wbe[0]; FRAME = (n == 1);

    while (!fin) begin
      @(negedge clk);
      xfer = !IRDY && !TRDY;
      stp  = !STOP;
      step();
      budget++;
      if (xfer) k++;
      if (budget > 80) begin
        chk("txn_timeout", budget, 0);
        FRAME = 1'b1; IRDY = 1'b1;
        sbq.delete();
        fin = 1;
      end else if (xfer && rst_at == k) begin
        #2 rst = 1'b1;
        #1 chk("async_rst_ctl", {DEVSEL, TRDY, STOP, AD_oe}, 4'b1110);
        chk("async_rst_ad", AD_out, 32'd0);
        sbq.delete();
        FRAME = 1'b1; IRDY = 1'b1;
        step();
        rst = 1'b0;
        fin = 1;
      end else if (xfer && FRAME) begin
        FRAME = 1'b1; IRDY = 1'b1;
        chk("backoff", {DEVSEL, TRDY, STOP, AD_oe}, 4'b1110);
        fin = 1;
      end else if (xfer && stp) begin
        FRAME = hold_stop ? 1'b0 : 1'b1;
        IRDY  = 1'b1;
        chk("disc_hold", {DEVSEL, TRDY, STOP}, 3'b010);
        if (hold_stop) begin
          step();
          chk("disc_hold2", {DEVSEL, TRDY, STOP}, 3'b010);
          FRAME = 1'b1;
        end
        step();
        chk("disc_release", {DEVSEL, TRDY, STOP, AD_oe}, 4'b1110);
        fin = 1;
      end else if (k == wait_at && waited < wait_len) begin
        chk("wait_hold", {DEVSEL, TRDY}, 2'b00);
        IRDY = 1'b1; FRAME = 1'b0;
        waited++;
      end else begin
        IRDY = 1'b0; AD_in = rd ? $urandom : wdat[k]; C_BE = wbe[k]; FRAME = (k == n - 1);
      end
    end
  endtask

  task automatic fill(input int n);
    for (int j = 0; j < n; j++) begin
      wdat[j] = $urandom;
      wbe[j]  = 4'h0;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  c;
    int          kind, n, wa;
    rst = 1'b1; FRAME = 1'b1; IRDY = 1'b1; C_BE = 4'h0; AD_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_devsel", DEVSEL, 32'd1);
    chk("rst_trdy",   TRDY,   32'd1);
    chk("rst_stop",   STOP,   32'd1);
    chk("rst_oe",     AD_oe,  32'd0);
    chk("rst_adout",  AD_out, 32'd0);
    rst = 1'b0;

    // Known buffer contents for the model.
    fill(DEPTH);
    txn(BASE, WR, DEPTH, -1, 0, 0, -1);

    // Single write then read back.
    wdat[0] = 32'hDEADBEEF; wbe[0] = 4'h0;
    txn(32'h1004, WR, 1, -1, 0, 0, -1);
    txn(32'h1004, RD, 1, -1, 0, 0, -1);

    // Three-word burst write then burst read.
    wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33;
    wbe[0] = 4'h0; wbe[1] = 4'h0; wbe[2] = 4'h0;
    txn(32'h1000, WR, 3, -1, 0, 0, -1);
    txn(32'h1000, RD, 3, -1, 0, 0, -1);

    // Byte-lane merge.
    wdat[0] = 32'hAABBCCDD; wbe[0] = 4'h0;
    txn(32'h1008, WR, 1, -1, 0, 0, -1);
    wdat[0] = 32'h11223344; wbe[0] = 4'b1010;
    txn(32'h1008, WR, 1, -1, 0, 0, -1);
    wbe[0] = 4'h0;
    txn(32'h1008, RD, 1, -1, 0, 0, -1);

    // Disconnect at the top of the buffer.
    fill(4);
    txn(32'h1038, WR, 4, -1, 0, 1, -1);
    txn(32'h1038, RD, 4, -1, 0, 0, -1);
    txn(32'h103C, RD, 2, -1, 0, 1, -1);

    // Address miss and unsupported command.
    txn(32'h2000, WR, 2, -1, 0, 0, -1);
    txn(32'h1000, 4'b0010, 1, -1, 0, 0, -1);

    // Wait states mid-burst.
    fill(6);
    txn(32'h1000, WR, 6, 2, 3, 0, -1);
    txn(32'h1000, RD, 6, 3, 3, 0, -1);

    // Reset during a write burst, then normal decode.
    fill(6);
    txn(32'h1010, WR, 6, -1, 0, 0, 2);
    txn(32'h1010, RD, 5, -1, 0, 0, -1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      n    = $urandom_range(1, 6);
      wa   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : -1;
      for (int j = 0; j < 32; j++) begin
        wdat[j] = $urandom;
        wbe[j]  = 4'($urandom_range(0, 15));
      end
      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      c = ($urandom_range(0, 1) == 1) ? WR : RD;
      if (kind == 0) a = 32'h2000 + 32'(4 * $urandom_range(0, 15));
      if (kind == 1) c = 4'b0010;
      txn(a, c, n, wa, $urandom_range(1, 3), 1'($urandom_range(0, 1)), -1);
    end

    step();
    chk("sb_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
